// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 definitions: multiplier-arbiter limits and tag width helper.
package secp256k1_pkg;

  localparam int MULT_ARB_MAX_REQ = 8;

  function automatic int mult_arb_tag_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/secp256k1_mult_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each multiply still in flight.
module secp256k1_mult_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_dat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/secp256k1_mult_arb.sv
// Round-robin arbiter sharing one secp256k1_mult_mod between NUM_REQ requesters.
// Optional grant counters: define SECP256K1_MULT_ARB_STATS_EN.
module secp256k1_mult_arb
  import secp256k1_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CTL_BITS = 16,
  parameter int MAX_OUT  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ*512-1:0]       i_req_dat,
  input  logic [NUM_REQ*CTL_BITS-1:0]  i_req_ctl,
  input  logic [NUM_REQ-1:0]           i_req_val,
  output logic [NUM_REQ-1:0]           o_req_rdy,
  output logic [511:0]                 o_mult_dat,
  output logic [CTL_BITS-1:0]          o_mult_ctl,
  output logic                         o_mult_val,
  input  logic                         i_mult_rdy,
  input  logic [255:0]                 i_mult_dat,
  input  logic [CTL_BITS-1:0]          i_mult_ctl,
  input  logic                         i_mult_val,
  input  logic                         i_mult_err,
  output logic                         o_mult_rdy,
  output logic [255:0]                 o_rsp_dat,
  output logic [CTL_BITS-1:0]          o_rsp_ctl,
  output logic                         o_rsp_err,
  output logic [NUM_REQ-1:0]           o_rsp_val,
  input  logic [NUM_REQ-1:0]           i_rsp_rdy,
  output logic                         o_err_unexp,
  output logic [NUM_REQ*32-1:0]        o_stat_grant
);

  localparam int TAG_W = mult_arb_tag_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [TAG_W-1:0]    r_ptr;
  logic [511:0]        r_mult_dat;
  logic [CTL_BITS-1:0] r_mult_ctl;
  logic                r_mult_val;
  logic                r_err_unexp;

  logic [TAG_W-1:0]    w_win;
  logic [TAG_W-1:0]    w_nxt_ptr;
  logic [TAG_W-1:0]    w_head;
  logic                w_any;
  logic                w_free;
  logic                w_grant;
  logic                w_pop;
  logic                w_empty;
  logic                w_head_rdy;
  logic [CNT_W-1:0]    w_count;
  logic [511:0]        w_sel_dat;
  logic [CTL_BITS-1:0] w_sel_ctl;
  int                  w_dist;
  int                  w_best;

  // Winner is the valid requester at the smallest rotational distance from r_ptr.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j >= int'(r_ptr)) ? (j - int'(r_ptr)) : (j + NUM_REQ - int'(r_ptr));
      if (i_req_val[j] && (w_dist < w_best)) begin
        w_any  = 1'b1;
        w_win  = TAG_W'(j);
        w_best = w_dist;
      end
    end
  end

  assign w_free    = !r_mult_val || i_mult_rdy;
  assign w_grant   = w_free && (w_count < CNT_W'(MAX_OUT)) && w_any && !i_rst;
  assign w_nxt_ptr = (w_win == TAG_W'(NUM_REQ - 1)) ? '0 : (w_win + 1'b1);

  always_comb begin
    o_req_rdy = '0;
    w_sel_dat = '0;
    w_sel_ctl = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win == TAG_W'(j)) begin
        o_req_rdy[j] = w_grant;
        w_sel_dat    = i_req_dat[j*512 +: 512];
        w_sel_ctl    = i_req_ctl[j*CTL_BITS +: CTL_BITS];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mult_val  <= 1'b0;
      r_mult_dat  <= '0;
      r_mult_ctl  <= '0;
      r_ptr       <= '0;
      r_err_unexp <= 1'b0;
    end else begin
      if (w_grant) begin
        r_mult_val <= 1'b1;
        r_mult_dat <= w_sel_dat;
        r_mult_ctl <= w_sel_ctl;
        r_ptr      <= w_nxt_ptr;
      end else if (w_free) begin
        r_mult_val <= 1'b0;
      end
      if (i_mult_val && w_empty) r_err_unexp <= 1'b1;
    end
  end

  assign o_mult_val  = r_mult_val;
  assign o_mult_dat  = r_mult_dat;
  assign o_mult_ctl  = r_mult_ctl;
  assign o_err_unexp = r_err_unexp;

  // Results come back in issue order, so the FIFO head names the owner.
  always_comb begin
    o_rsp_val  = '0;
    w_head_rdy = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_head == TAG_W'(j)) begin
        o_rsp_val[j] = i_mult_val && !w_empty;
        w_head_rdy   = i_rsp_rdy[j];
      end
    end
  end

  assign o_mult_rdy = w_empty ? 1'b1 : w_head_rdy;
  assign w_pop      = i_mult_val && o_mult_rdy && !w_empty;
  assign o_rsp_dat  = i_mult_dat;
  assign o_rsp_ctl  = i_mult_ctl;
  assign o_rsp_err  = i_mult_err;

  secp256k1_mult_arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (TAG_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_grant),
    .i_dat   (w_win),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef SECP256K1_MULT_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] r_stat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stat <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (o_req_rdy[j]) r_stat[j] <= r_stat[j] + 32'd1;
      end
    end
  end

  assign o_stat_grant = r_stat;
`else
  assign o_stat_grant = '0;
`endif

endmodule

// File: tb/tb_secp256k1_mult_arb.sv
// Scoreboard bench for secp256k1_mult_arb with a behavioural in-order multiplier model.
module tb_secp256k1_mult_arb;

  localparam int NR = 2;
  localparam int CB = 16;
  localparam int MO = 4;

  localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] PM1 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2E;
  localparam logic [255:0] PM2 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D;
  localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GX2 = 256'hF37CCCFDF3B97758AB40C52B9D0E160E0537F9B65B9C51B2B3E502B62DF02F30;

`ifdef SECP256K1_MULT_ARB_STATS_EN
  localparam logic [31:0] EXP_STAT1 = 32'd5;
`else
  localparam logic [31:0] EXP_STAT1 = 32'd0;
`endif

  typedef struct packed {
    logic [255:0] a;
    logic [255:0] b;
    logic [15:0]  ctl;
    logic [255:0] exp;
  } vec_t;

  typedef struct {
    int           idx;
    logic [255:0] dat;
    logic [15:0]  ctl;
  } exp_t;

  typedef struct packed {
    logic [255:0] d;
    logic [15:0]  c;
  } mres_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NR*512-1:0]    req_dat = '0;
  logic [NR*CB-1:0]     req_ctl = '0;
  logic [NR-1:0]        req_val = '0;
  logic [NR-1:0]        req_rdy;
  logic [511:0]         mult_dat_o;
  logic [CB-1:0]        mult_ctl_o;
  logic                 mult_val_o;
  logic                 mult_in_rdy = 1'b1;
  logic [255:0]         m_dat = '0;
  logic [CB-1:0]        m_ctl = '0;
  logic                 m_val = 1'b0;
  logic                 m_err = 1'b0;
  logic                 inj_val = 1'b0;
  logic                 mult_val_i;
  logic                 mult_rdy_o;
  logic [255:0]         rsp_dat;
  logic [CB-1:0]        rsp_ctl;
  logic                 rsp_err;
  logic [NR-1:0]        rsp_val;
  logic [NR-1:0]        rsp_rdy = '1;
  logic                 err_unexp;
  logic [NR*32-1:0]     stat_grant;

  assign mult_val_i = m_val | inj_val;

  int    pass_cnt = 0;
  int    total    = 0;
  vec_t  rq0[$];
  vec_t  rq1[$];
  exp_t  sb[$];
  int    acc_log[$];
  mres_t mq[$];
  logic [511:0] m_pr;

  always #5 clk = ~clk;

  secp256k1_mult_arb #(.NUM_REQ(NR), .CTL_BITS(CB), .MAX_OUT(MO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_dat    (req_dat),
    .i_req_ctl    (req_ctl),
    .i_req_val    (req_val),
    .o_req_rdy    (req_rdy),
    .o_mult_dat   (mult_dat_o),
    .o_mult_ctl   (mult_ctl_o),
    .o_mult_val   (mult_val_o),
    .i_mult_rdy   (mult_in_rdy),
    .i_mult_dat   (m_dat),
    .i_mult_ctl   (m_ctl),
    .i_mult_val   (mult_val_i),
    .i_mult_err   (m_err),
    .o_mult_rdy   (mult_rdy_o),
    .o_rsp_dat    (rsp_dat),
    .o_rsp_ctl    (rsp_ctl),
    .o_rsp_err    (rsp_err),
    .o_rsp_val    (rsp_val),
    .i_rsp_rdy    (rsp_rdy),
    .o_err_unexp  (err_unexp),
    .o_stat_grant (stat_grant)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t get_vec(input int k);
    vec_t v;
    case (k % 8)
      0:       v = '{a: 256'd2,     b: 256'd3,  ctl: 16'h00C5, exp: 256'd6};
      1:       v = '{a: GX,         b: 256'd1,  ctl: 16'h0041, exp: GX};
      2:       v = '{a: 256'd5,     b: 256'd7,  ctl: 16'h1280, exp: 256'd35};
      3:       v = '{a: PM1,        b: 256'd2,  ctl: 16'h00C0, exp: PM2};
      4:       v = '{a: 256'h10,    b: 256'h10, ctl: 16'hABCD, exp: 256'h100};
      5:       v = '{a: GX,         b: 256'd2,  ctl: 16'h0003, exp: GX2};
      6:       v = '{a: 256'd0,     b: GX,      ctl: 16'hFFFF, exp: 256'd0};
      default: v = '{a: 256'd3,     b: 256'd3,  ctl: 16'h7E40, exp: 256'd9};
    endcase
    return v;
  endfunction

  // Multiplier model: accepts when ready, returns (a*b) mod p in order, one cycle later at the earliest.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_val <= 1'b0;
      m_dat <= '0;
      m_ctl <= '0;
    end else begin
      if (m_val && mult_rdy_o) void'(mq.pop_front());
      if (mult_val_o && mult_in_rdy) begin
        m_pr = (512'(mult_dat_o[255:0]) * 512'(mult_dat_o[511:256])) % 512'(P);
        mq.push_back({m_pr[255:0], mult_ctl_o});
      end
      m_val <= (mq.size() > 0);
      if (mq.size() > 0) begin
        m_dat <= mq[0].d;
        m_ctl <= mq[0].c;
      end
    end
  end

  // Request driver: present each requester's queue head just after the edge.
  initial forever begin
    @(posedge clk);
    #1;
    req_val[0] = (rq0.size() > 0);
    req_val[1] = (rq1.size() > 0);
    if (rq0.size() > 0) begin
      req_dat[511:0] = {rq0[0].b, rq0[0].a};
      req_ctl[15:0]  = rq0[0].ctl;
    end
    if (rq1.size() > 0) begin
      req_dat[1023:512] = {rq1[0].b, rq1[0].a};
      req_ctl[31:16]    = rq1[0].ctl;
    end
  end

  // Monitor: check delivered responses, then record accepted requests as expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(rsp_val) > 1) check("rsp_onehot", 256'(rsp_val), 256'd1);
      for (int i = 0; i < NR; i++) begin
        if (rsp_val[i] && rsp_rdy[i]) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 256'(rsp_val), 256'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_idx", 256'(i), 256'(e.idx));
            check("rsp_dat", rsp_dat, e.dat);
            check("rsp_ctl", 256'(rsp_ctl), 256'(e.ctl));
            check("rsp_err", 256'(rsp_err), 256'd0);
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_val[i] && req_rdy[i]) begin
          vec_t v;
          v = (i == 0) ? rq0.pop_front() : rq1.pop_front();
          sb.push_back('{idx: i, dat: v.exp, ctl: v.ctl});
          acc_log.push_back(i);
        end
      end
    end
  end

  task automatic clear_bench();
    rq0.delete();
    rq1.delete();
    sb.delete();
    acc_log.delete();
    inj_val = 1'b0;
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    clear_bench();
    rsp_rdy     = '1;
    mult_in_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (sb.size() == 0 && rq0.size() == 0 && rq1.size() == 0) break;
      @(posedge clk);
    end
    check(nm, 256'(sb.size() + rq0.size() + rq1.size()), 256'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_req_rdy",   256'(req_rdy),    256'd0);
    check("rst_mult_val",  256'(mult_val_o), 256'd0);
    check("rst_rsp_val",   256'(rsp_val),    256'd0);
    check("rst_mult_rdy",  256'(mult_rdy_o), 256'd1);
    check("rst_err_unexp", 256'(err_unexp),  256'd0);
    check("rst_stat",      256'(stat_grant), 256'd0);
    rst = 1'b0;

    // 1: single request with ctl passthrough
    apply_rst();
    rq0.push_back(get_vec(0));
    wait_drain("t1_drain", 50);

    // 2: round-robin with both requesters continuously valid
    apply_rst();
    for (int k = 0; k < 8; k++) begin
      rq0.push_back(get_vec(k));
      rq1.push_back(get_vec(7 - k));
    end
    wait_drain("t2_drain", 300);
    check("t2_acc_cnt", 256'(acc_log.size()), 256'd16);
    for (int k = 0; k < 16 && k < acc_log.size(); k++) check("t2_rr_order", 256'(acc_log[k]), 256'(k % 2));

    // 3: response backpressure on requester 1
    apply_rst();
    rsp_rdy = 2'b01;
    rq0.push_back(get_vec(1));
    rq0.push_back(get_vec(3));
    rq1.push_back(get_vec(5));
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rsp_val[1]) break;
    end
    check("t3_head_val", 256'(rsp_val),    256'h2);
    check("t3_mult_rdy", 256'(mult_rdy_o), 256'd0);
    repeat (3) @(negedge clk);
    check("t3_stall_rdy", 256'(mult_rdy_o), 256'd0);
    check("t3_stall_sb",  256'(sb.size()),  256'd2);
    @(posedge clk);
    #2 rsp_rdy = 2'b11;
    wait_drain("t3_drain", 50);

    // 4: full boundary at MAX_OUT
    apply_rst();
    rsp_rdy = 2'b00;
    for (int k = 0; k < 4; k++) begin
      rq0.push_back(get_vec(k));
      rq1.push_back(get_vec(k + 4));
    end
    repeat (12) @(negedge clk);
    check("t4_acc_cnt",  256'(acc_log.size()), 256'd4);
    check("t4_full_rdy", 256'(req_rdy),        256'd0);
    @(posedge clk);
    #2 rsp_rdy = 2'b01;
    @(negedge clk);
    check("t4_pop_rsp", 256'(rsp_val), 256'h1);
    check("t4_pop_rdy", 256'(req_rdy), 256'd0);
    @(posedge clk);
    #2 rsp_rdy = 2'b00;
    @(negedge clk);
    check("t4_next_rdy", 256'(req_rdy), 256'h1);
    @(posedge clk);
    #2 rsp_rdy = 2'b11;
    wait_drain("t4_drain", 200);

    // 5: asynchronous reset with three multiplies in flight
    apply_rst();
    rsp_rdy = 2'b00;
    rq0.push_back(get_vec(2));
    rq1.push_back(get_vec(4));
    rq0.push_back(get_vec(6));
    for (int c = 0; c < 30; c++) begin
      if (acc_log.size() >= 3) break;
      @(posedge clk);
    end
    check("t5_inflight", 256'(acc_log.size()), 256'd3);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_mult_val",  256'(mult_val_o), 256'd0);
    check("t5_req_rdy",   256'(req_rdy),    256'd0);
    check("t5_rsp_val",   256'(rsp_val),    256'd0);
    check("t5_mult_rdy",  256'(mult_rdy_o), 256'd1);
    check("t5_err_unexp", 256'(err_unexp),  256'd0);
    clear_bench();
    rsp_rdy = 2'b11;
    rq0.push_back(get_vec(7));
    rq1.push_back(get_vec(0));
    @(posedge clk);
    @(negedge clk);
    check("t5_rdy_in_rst", 256'(req_rdy), 256'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_drain("t5_drain", 50);
    check("t5_ptr_zero", 256'(acc_log.size() > 0 ? acc_log[0] : -1), 256'd0);
    repeat (3) @(posedge clk);
    #2;
    check("t5_no_err", 256'(err_unexp), 256'd0);
    inj_val = 1'b1;
    @(negedge clk);
    check("t5_inj_mult_rdy", 256'(mult_rdy_o), 256'd1);
    check("t5_inj_rsp_val",  256'(rsp_val),    256'd0);
    @(posedge clk);
    #2 inj_val = 1'b0;
    @(negedge clk);
    check("t5_err_unexp_set", 256'(err_unexp), 256'd1);
    repeat (2) @(negedge clk);
    check("t5_err_sticky", 256'(err_unexp), 256'd1);

    // 6: grant statistics
    apply_rst();
    check("t6_err_cleared", 256'(err_unexp), 256'd0);
    for (int k = 0; k < 5; k++) rq1.push_back(get_vec(k));
    wait_drain("t6_drain", 100);
    check("t6_stat1", 256'(stat_grant[63:32]), 256'(EXP_STAT1));
    check("t6_stat0", 256'(stat_grant[31:0]),  256'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/secp256k1_mult_arb.md
# secp256k1_mult_arb

Round-robin arbiter that shares one `secp256k1_mult_mod` instance between `NUM_REQ` requesters, e.g. `secp256k1_point_mult` and a signature-verify sequencer. It forwards one multiply per grant and records the requester index in an in-order tag FIFO. Each result is routed back to the requester that issued it, and request and response `ctl` fields pass through unmodified. It sits between the requesters' multiplier ports and the single multiplier.

## Interface

Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `CTL_BITS`, 16: ctl width; `ctl[7:6]` carries the multiplier command and is passed through untouched.
- `MAX_OUT`, 8: maximum multiplies in flight, which sets the tag FIFO depth; power of two.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous active-high reset.
- `i_req_dat` in `NUM_REQ*512`: per requester, `{b[255:0], a[255:0]}`.
- `i_req_ctl` in `NUM_REQ*CTL_BITS`: per-requester ctl.
- `i_req_val` in `NUM_REQ`: request valid.
- `o_req_rdy` out `NUM_REQ`: request accepted this cycle when val&rdy.
- `o_mult_dat` out 512: to multiplier `i_dat_b`/`i_dat_a`.
- `o_mult_ctl` out `CTL_BITS`: to multiplier `i_ctl`.
- `o_mult_val` out 1: to multiplier `i_val`.
- `i_mult_rdy` in 1: from multiplier `o_rdy`.
- `i_mult_dat` in 256: multiplier result.
- `i_mult_ctl` in `CTL_BITS`: multiplier `o_ctl`.
- `i_mult_val` in 1: multiplier result valid.
- `i_mult_err` in 1: multiplier `o_err`.
- `o_mult_rdy` out 1: to multiplier `i_rdy`.
- `o_rsp_dat` out 256: result, shared by all requesters.
- `o_rsp_ctl` out `CTL_BITS`: ctl, shared by all requesters.
- `o_rsp_err` out 1: error, shared by all requesters.
- `o_rsp_val` out `NUM_REQ`: one-hot response valid.
- `i_rsp_rdy` in `NUM_REQ`: per-requester response ready.
- `o_err_unexp` out 1: sticky; a response arrived with the tag FIFO empty.
- `o_stat_grant` out `NUM_REQ*32`: grant counters (see Configuration).

## Operation

Request path:
- Output stage is a single register holding `o_mult_dat`, `o_mult_ctl` and `o_mult_val`.
- The stage is free when `!o_mult_val || i_mult_rdy`.
- Each cycle, if the stage is free and `count < MAX_OUT`, the arbiter picks the first `i_req_val[i]` searching from `ptr`, wrapping modulo `NUM_REQ`.
- Only the winner sees `o_req_rdy[i]=1`; all other `o_req_rdy` bits are 0.
- On acceptance:
  - the output register loads the winner's dat and ctl, and `o_mult_val` is set;
  - the winner index is pushed into the tag FIFO;
  - `ptr` becomes winner+1, wrapping modulo `NUM_REQ`.
- With no valid requester, `ptr` holds.
- If the stage is free and nothing is accepted, `o_mult_val` clears.
- Grants are per transfer; there is no locking across multiple beats.

Response path (combinational):
- Let `head` be the FIFO head index.
- `o_rsp_val[head] = i_mult_val && !empty`; all other `o_rsp_val` bits are 0.
- `o_mult_rdy = empty ? 1 : i_rsp_rdy[head]`.
- `o_rsp_dat`, `o_rsp_ctl` and `o_rsp_err` are `i_mult_dat`, `i_mult_ctl` and `i_mult_err` passed straight through.
- The FIFO pops on `i_mult_val && o_mult_rdy && !empty`.

Counting and boundaries:
- `count` is the FIFO occupancy and counts from request acceptance to response pop.
  - It increments on push, decrements on pop, and is unchanged when both happen in the same cycle.
- Full: the full check uses the registered `count`. At `count == MAX_OUT` no grant is issued, even if a pop happens in the same cycle.
- Empty:
  - a response arriving with the FIFO empty is dropped (`o_mult_rdy=1`) and sets `o_err_unexp`;
  - `o_err_unexp` clears only on reset.
- The multiplier returns results in order; the arbiter relies on this.

Reset (asynchronous, any time, including with multiplies in flight):
- `o_mult_val=0`, `ptr=0`, FIFO empty, `count=0`, `o_err_unexp=0`, stats cleared.
- Multiplies in flight are abandoned. The integrator resets the multiplier on the same `i_rst`.

## Timing

- Request to `o_mult_val`: 1 cycle after acceptance.
- Multiplier result to requester: 0 cycles (combinational).
- Back-to-back grants are possible at one per cycle while `i_mult_rdy=1` and `count < MAX_OUT`.
- Fairness: with all requesters continuously valid, each is granted once every `NUM_REQ` accepted transfers.
- Reset values of outputs:
  - `o_req_rdy=0`, `o_mult_val=0`, `o_rsp_val=0`;
  - `o_mult_rdy=1`, since the FIFO is empty;
  - `o_err_unexp=0`, `o_stat_grant=0`.

## Configuration

- Macro: `SECP256K1_MULT_ARB_STATS_EN`.
- Defined: one 32-bit counter per requester increments on each accepted request and wraps at 2^32.
- Undefined: the counter logic is omitted and `o_stat_grant` is tied to 0. The port list is identical in both cases.

## Structure

- Add to `secp256k1_pkg`:
  - constant `MULT_ARB_MAX_REQ = 8`;
  - function returning `$clog2` of `NUM_REQ`, floored at 1, for the tag width.
- Sub-module `secp256k1_mult_arb_tag_fifo`: synchronous FIFO, `MAX_OUT` entries of tag width, with push, pop, head, empty and count.
- Arbitration, the output register and stats live in the top module.

## Test plan

1. **Single request, ctl passthrough.** `NUM_REQ=2`, requester 0 sends `a=2`, `b=3`, `ctl=0x00C5`.
   - Required: `o_rsp_val=2'b01`, `o_rsp_dat=6`, `o_rsp_ctl=0x00C5`.
2. **Round-robin fairness.** Requesters 0 and 1 both held valid for 8 requests each, multiplier always ready.
   - Required: accepted order is 0,1,0,1,…
   - Required: each response returns to its issuer with the correct product, e.g. `a=Gx`, `b=1` gives `Gx`.
3. **Response backpressure.** `i_rsp_rdy[1]=0` while requester 1's result is at the head.
   - Required: `o_mult_rdy=0` and the multiplier stalls.
   - Required: releasing `i_rsp_rdy[1]` delivers results in issue order.
4. **Full boundary.** `MAX_OUT=4`, all `i_rsp_rdy=0`, continuous requests.
   - Required: exactly 4 acceptances, then all `o_req_rdy=0`.
   - Required: after one pop, the next grant happens no earlier than the following cycle.
5. **Reset mid-operation and unexpected response.**
   - Assert `i_rst` with 3 multiplies in flight. Required: outputs at reset values immediately (asynchronous); `ptr=0`.
   - Inject a bare `i_mult_val` with the FIFO empty. Required: `o_err_unexp=1`.
6. **Stats.** `SECP256K1_MULT_ARB_STATS_EN` defined, 5 grants to requester 1.
   - Required: `o_stat_grant[63:32]=5`.
   - With the macro undefined: `o_stat_grant` reads 0.
